// File: rtl/sysid_pkg.sv
// Shared constants and FSM state encoding for the system ID reader.
// Word addresses of the sysid slave, stall counter width, state type.
package sysid_pkg;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/sysid_rd_xact.sv
// Single Avalon-MM read: holds read/address through waitrequest and
// times out a stalled read.
// Ports: clk, reset, go/go_addr (launch), avm_* (bus side),
//        rd_done, rd_data, rd_timeout (completion strobes to the sequencer).
module sysid_rd_xact
    import sysid_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        go_addr,
    output logic        avm_read,
    output logic        avm_address,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        rd_done,
    output logic [31:0] rd_data,
    output logic        rd_timeout
);

    localparam logic [STALL_CNT_W-1:0] TMO = STALL_CNT_W'(TIMEOUT_CYCLES);

    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   stall_limit;

    // The limit only matters while a read is actually stalled.
    assign stall_limit = (stall_cnt == TMO);

    assign rd_done    = avm_read & ~avm_waitrequest;
    assign rd_timeout = avm_read & avm_waitrequest & stall_limit;
    assign rd_data    = avm_readdata;

    // A launch takes priority so a completing read can hand straight
    // over to the next one without a gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            stall_cnt   <= '0;
        end else if (go) begin
            avm_read    <= 1'b1;
            avm_address <= go_addr;
            stall_cnt   <= '0;
        end else if (avm_read) begin
            if (!avm_waitrequest || stall_limit) begin
                avm_read <= 1'b0;
            end else begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/sysid_reader.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words
// and checks them against expected values.
// Ports: clk, reset, start; avm_* to sysid slave; busy, done, id_ok,
//        ts_ok, timeout, sysid_id, sysid_ts to the supervisor.
module sysid_reader
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd1243933255,
    parameter logic [31:0] EXPECTED_TS    = 32'd1260450551,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] sysid_id,
    output logic [31:0] sysid_ts
);

    state_t      state_q;
    state_t      state_d;
    logic        go;
    logic        go_addr;
    logic        rd_done;
    logic        rd_timeout;
    logic [31:0] rd_data;

    sysid_rd_xact #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_xact (
        .clk            (clk),
        .reset          (reset),
        .go             (go),
        .go_addr        (go_addr),
        .avm_read       (avm_read),
        .avm_address    (avm_address),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .rd_done        (rd_done),
        .rd_data        (rd_data),
        .rd_timeout     (rd_timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        go_addr = SYSID_ADDR_ID;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    go      = 1'b1;
                    state_d = RD_ID;
                end
            end
            RD_ID: begin
                if (rd_done) begin
                    go      = 1'b1;
                    go_addr = SYSID_ADDR_TS;
                    state_d = RD_TS;
                end else if (rd_timeout) begin
                    state_d = FIN;
                end
            end
            RD_TS: begin
                if (rd_done || rd_timeout) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // done is raised on the edge that enters FIN so it is visible
    // for exactly the single FIN cycle, with busy already low.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            sysid_id <= '0;
            sysid_ts <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        id_ok   <= 1'b0;
                        ts_ok   <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                RD_ID: begin
                    if (rd_done) begin
                        sysid_id <= rd_data;
                        id_ok    <= (rd_data == EXPECTED_ID);
                    end else if (rd_timeout) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                RD_TS: begin
                    if (rd_done) begin
                        sysid_ts <= rd_data;
                        ts_ok    <= (rd_data == EXPECTED_TS);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end else if (rd_timeout) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                FIN: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule
